// File: rtl/crc_frame_checker_if.sv
// Valid/ready beat bus between the upstream nibble CRC generator and the checker.
// The master drives payload nibbles and the received CRC; the slave answers with ready.
interface crc_frame_checker_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] data_in;
    logic [4:0] crc_rx;

    modport master (output in_valid, output data_in, output crc_rx, input in_ready);
    modport slave  (input in_valid, input data_in, input crc_rx, output in_ready);
endinterface

// File: rtl/crc_frame_checker.sv
// Receive-side CRC-5 frame checker: recomputes the CRC over a fixed-length
// nibble payload, compares it with the received CRC beat, strobes a one-cycle
// verdict and keeps wrapping frame / saturating error statistics.
module crc_frame_checker #(
    parameter int         FRAME_NIBBLES = 4,
    parameter logic [4:0] POLY          = 5'h05,
    parameter logic [4:0] INIT          = 5'h00
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    crc_frame_checker_if.slave        bus,
    output logic                      done,
    output logic                      crc_ok,
    output logic [4:0]                crc_calc,
    output logic [7:0]                frame_count,
    output logic [7:0]                err_count
);

    typedef enum logic [1:0] {
        RECV     = 2'd0,
        CRC_WAIT = 2'd1,
        REPORT   = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(FRAME_NIBBLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] crc_q, crc_d;
    logic       ok_q, ok_d;
    logic [4:0] calc_q, calc_d;
    logic [7:0] frames_q, frames_d;
    logic [7:0] errs_q, errs_d;
    logic       accept;

    // Four MSB-first serial LFSR steps collapsed into one combinational nibble update.
    function automatic logic [4:0] crcNibble(input logic [4:0] cIn, input logic [3:0] nib);
        logic [4:0] c;
        logic       fb;
        c = cIn;
        for (int i = 3; i >= 0; i--) begin
            fb = c[4] ^ nib[i];
            c  = {c[3:0], 1'b0} ^ (fb ? POLY : 5'h00);
        end
        return c;
    endfunction

    assign accept = bus.in_valid && bus.in_ready;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RECV;
        else        state_q <= state_d;
    end

    // Next-state decode; flush always returns to RECV and discards any beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RECV:     if (accept && cnt_q == LAST_CNT) state_d = CRC_WAIT;
            CRC_WAIT: if (accept) state_d = REPORT;
            REPORT:   state_d = RECV;
            default:  state_d = RECV;
        endcase
        if (flush) state_d = RECV;
    end

    // Outputs decoded from state: ready except while reporting, verdict strobe in REPORT.
    always_comb begin
        bus.in_ready = (state_q != REPORT);
        done         = (state_q == REPORT);
    end

    // Datapath next values: CRC accumulation, nibble count, verdict and statistics.
    always_comb begin
        cnt_d    = cnt_q;
        crc_d    = crc_q;
        ok_d     = ok_q;
        calc_d   = calc_q;
        frames_d = frames_q;
        errs_d   = errs_q;
        if (flush) begin
            cnt_d = 8'd0;
            crc_d = INIT;
        end else begin
            case (state_q)
                RECV: begin
                    if (accept) begin
                        crc_d = crcNibble(crc_q, bus.data_in);
                        cnt_d = (cnt_q == LAST_CNT) ? 8'd0 : cnt_q + 8'd1;
                    end
                end
                CRC_WAIT: begin
                    if (accept) begin
                        ok_d     = (crc_q == bus.crc_rx);
                        calc_d   = crc_q;
                        frames_d = frames_q + 8'd1;
                        if (crc_q != bus.crc_rx && errs_q != 8'hFF) errs_d = errs_q + 8'd1;
                    end
                end
                REPORT:  crc_d = INIT;
                default: crc_d = INIT;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= 8'd0;
            crc_q    <= INIT;
            ok_q     <= 1'b0;
            calc_q   <= 5'h00;
            frames_q <= 8'd0;
            errs_q   <= 8'd0;
        end else begin
            cnt_q    <= cnt_d;
            crc_q    <= crc_d;
            ok_q     <= ok_d;
            calc_q   <= calc_d;
            frames_q <= frames_d;
            errs_q   <= errs_d;
        end
    end

    assign crc_ok      = ok_q;
    assign crc_calc    = calc_q;
    assign frame_count = frames_q;
    assign err_count   = errs_q;

endmodule

// File: tb/tb_crc_frame_checker.sv
// Self-checking bench for crc_frame_checker: directed scenarios plus random
// frames compared against a polynomial-division CRC reference model.
module tb_crc_frame_checker;

    logic clk = 1'b0;
    logic reset;
    logic flushA, flushB;

    logic       doneA, crcOkA, doneB, crcOkB;
    logic [4:0] crcCalcA, crcCalcB;
    logic [7:0] frameCountA, errCountA, frameCountB, errCountB;

    crc_frame_checker_if busA ();
    crc_frame_checker_if busB ();

    int         nChecks = 0;
    int         nFail = 0;
    int         tbCycle = 0;
    int         doneCountA = 0;
    int         modelDones = 0;
    logic [7:0] modelFrames = 8'd0;
    logic [7:0] modelErrs = 8'd0;

    // 10 ns clock.
    always #5 clk = ~clk;

    crc_frame_checker #(.FRAME_NIBBLES(2), .POLY(5'h05), .INIT(5'h00)) dutA (
        .clk(clk), .reset(reset), .flush(flushA), .bus(busA),
        .done(doneA), .crc_ok(crcOkA), .crc_calc(crcCalcA),
        .frame_count(frameCountA), .err_count(errCountA)
    );

    crc_frame_checker #(.FRAME_NIBBLES(1), .POLY(5'h05), .INIT(5'h00)) dutB (
        .clk(clk), .reset(reset), .flush(flushB), .bus(busB),
        .done(doneB), .crc_ok(crcOkB), .crc_calc(crcCalcB),
        .frame_count(frameCountB), .err_count(errCountB)
    );

    // Count verdict strobes on the falling edge, well away from register updates.
    always @(negedge clk) begin
        if (doneA === 1'b1) doneCountA++;
    end

    // Reference CRC: remainder of (message * x^5) divided by x^5+x^2+1 over GF(2).
    function automatic logic [4:0] refCrc(input logic [63:0] msg, input int nBits);
        logic [68:0] r;
        r = 69'(msg) << 5;
        for (int i = nBits + 4; i >= 5; i--) begin
            if (r[i]) r = r ^ (69'h25 << (i - 5));
        end
        return r[4:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tbCycle++;
    endtask

    task automatic idleA(input int n);
        busA.in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present one beat on bus A (optionally after a random idle gap) and wait, bounded, for acceptance.
    task automatic applyStimulus(input logic [3:0] d, input logic [4:0] c, input bit gaps);
        bit took;
        if (gaps && $urandom_range(0, 2) == 0) begin
            busA.in_valid = 1'b0;
            busA.data_in  = 4'($urandom);
            busA.crc_rx   = 5'($urandom);
            tick();
        end
        busA.in_valid = 1'b1;
        busA.data_in  = d;
        busA.crc_rx   = c;
        took = 1'b0;
        for (int t = 0; t < 8 && !took; t++) begin
            took = busA.in_ready;
            tick();
        end
        if (!took) checkOutput("beat_timeout", 32'(took), 32'd1);
    endtask

    // Send a two-nibble frame plus CRC beat and check the verdict cycle against the model.
    task automatic frameA(input logic [3:0] n0, input logic [3:0] n1, input logic [4:0] rx,
                          input bit gaps, input string tag);
        logic [4:0] expCrc;
        applyStimulus(n0, 5'($urandom), gaps);
        applyStimulus(n1, 5'($urandom), gaps);
        applyStimulus(4'($urandom), rx, gaps);
        expCrc = refCrc({56'd0, n0, n1}, 8);
        modelFrames = modelFrames + 8'd1;
        if (expCrc != rx && modelErrs != 8'hFF) modelErrs = modelErrs + 8'd1;
        modelDones++;
        checkOutput({tag, "_done"},   32'(doneA), 32'd1);
        checkOutput({tag, "_ready"},  32'(busA.in_ready), 32'd0);
        checkOutput({tag, "_ok"},     32'(crcOkA), 32'(expCrc == rx));
        checkOutput({tag, "_calc"},   32'(crcCalcA), 32'(expCrc));
        checkOutput({tag, "_frames"}, 32'(frameCountA), 32'(modelFrames));
        checkOutput({tag, "_errs"},   32'(errCountA), 32'(modelErrs));
    endtask

    initial begin
        int         c1;
        logic [3:0] r0, r1;
        logic [4:0] rx;

        reset = 1'b0;
        flushA = 1'b0;
        flushB = 1'b0;
        busA.in_valid = 1'b0; busA.data_in = 4'h0; busA.crc_rx = 5'h00;
        busB.in_valid = 1'b0; busB.data_in = 4'h0; busB.crc_rx = 5'h00;
        c1 = 0;

        // Reset values.
        #3;
        checkOutput("rst_done",   32'(doneA), 32'd0);
        checkOutput("rst_ok",     32'(crcOkA), 32'd0);
        checkOutput("rst_calc",   32'(crcCalcA), 32'd0);
        checkOutput("rst_frames", 32'(frameCountA), 32'd0);
        checkOutput("rst_errs",   32'(errCountA), 32'd0);
        checkOutput("rst_ready",  32'(busA.in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Good frame then bad frame with the same payload.
        frameA(4'h2, 4'h0, 5'h11, 1'b0, "good");
        checkOutput("good_calc_const", 32'(crcCalcA), 32'h11);
        idleA(1);
        checkOutput("good_done_low", 32'(doneA), 32'd0);
        idleA(1);
        checkOutput("good_pulses", doneCountA, modelDones);
        frameA(4'h2, 4'h0, 5'h10, 1'b0, "bad");
        idleA(2);

        // Single-nibble instance with valid toggling; idle-cycle data must be ignored.
        busB.in_valid = 1'b1; busB.data_in = 4'h2; busB.crc_rx = 5'h1F;
        tick();
        busB.in_valid = 1'b0; busB.data_in = 4'hF; busB.crc_rx = 5'h00;
        tick();
        busB.in_valid = 1'b1; busB.data_in = 4'h7; busB.crc_rx = 5'h0A;
        tick();
        checkOutput("b_done",   32'(doneB), 32'd1);
        checkOutput("b_ready",  32'(busB.in_ready), 32'd0);
        checkOutput("b_ok",     32'(crcOkB), 32'd1);
        checkOutput("b_calc",   32'(crcCalcB), 32'(refCrc(64'h2, 4)));
        checkOutput("b_frames", 32'(frameCountB), 32'd1);
        busB.in_valid = 1'b0;
        tick();
        checkOutput("b_done_low", 32'(doneB), 32'd0);

        // Flush after the first nibble, then a complete good frame.
        applyStimulus(4'h3, 5'h00, 1'b0);
        busA.in_valid = 1'b0;
        flushA = 1'b1;
        tick();
        flushA = 1'b0;
        frameA(4'h2, 4'h0, 5'h11, 1'b0, "postflush");
        idleA(2);
        checkOutput("flush_pulses", doneCountA, modelDones);

        // Flush together with the CRC beat discards the frame.
        applyStimulus(4'h1, 5'h00, 1'b0);
        applyStimulus(4'h4, 5'h00, 1'b0);
        busA.in_valid = 1'b1;
        busA.crc_rx = refCrc(64'h14, 8);
        flushA = 1'b1;
        tick();
        flushA = 1'b0;
        busA.in_valid = 1'b0;
        checkOutput("flushcrc_done",   32'(doneA), 32'd0);
        checkOutput("flushcrc_ready",  32'(busA.in_ready), 32'd1);
        checkOutput("flushcrc_frames", 32'(frameCountA), 32'(modelFrames));
        idleA(2);
        checkOutput("flushcrc_pulses", doneCountA, modelDones);

        // Random frames with random idle gaps, half with a correct CRC.
        for (int f = 0; f < 24; f++) begin
            r0 = 4'($urandom);
            r1 = 4'($urandom);
            rx = ($urandom_range(0, 1) == 1) ? refCrc({56'd0, r0, r1}, 8) : 5'($urandom);
            frameA(r0, r1, rx, 1'b1, "rand");
        end
        idleA(2);
        checkOutput("rand_pulses", doneCountA, modelDones);

        // Fresh counters, then 256 back-to-back bad frames.
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        modelFrames = 8'd0;
        modelErrs = 8'd0;
        tick();
        for (int f = 1; f <= 256; f++) begin
            frameA(4'h2, 4'h0, 5'h10, 1'b0, "sat");
            if (f == 1) c1 = tbCycle;
            if (f == 255) begin
                checkOutput("sat_errs_255",   32'(errCountA), 32'd255);
                checkOutput("sat_frames_255", 32'(frameCountA), 32'd255);
            end
            if (f == 256) begin
                checkOutput("sat_errs_256",   32'(errCountA), 32'd255);
                checkOutput("sat_frames_256", 32'(frameCountA), 32'd0);
                checkOutput("sat_spacing",    tbCycle - c1, 4 * 255);
            end
        end
        idleA(2);
        checkOutput("sat_pulses", doneCountA, modelDones);

        // Asynchronous reset mid-frame, between clock edges.
        frameA(4'h2, 4'h0, 5'h11, 1'b0, "prereset");
        idleA(1);
        applyStimulus(4'h5, 5'h00, 1'b0);
        busA.in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        checkOutput("arst_done",   32'(doneA), 32'd0);
        checkOutput("arst_ok",     32'(crcOkA), 32'd0);
        checkOutput("arst_calc",   32'(crcCalcA), 32'd0);
        checkOutput("arst_frames", 32'(frameCountA), 32'd0);
        checkOutput("arst_errs",   32'(errCountA), 32'd0);
        checkOutput("arst_ready",  32'(busA.in_ready), 32'd1);
        #2;
        reset = 1'b1;
        modelFrames = 8'd0;
        modelErrs = 8'd0;
        tick();
        frameA(4'h2, 4'h0, 5'h11, 1'b0, "postreset");
        idleA(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
